note_sequencer: RTL and testbench
=================================

# note_sequencer

Parametrised tempo-driven note sequencer for the rhythm-game datapath. It replaces the fixed free-running 6-bit address stepper with a controlled sequencer that walks a programmable address window of note memory at one of eight selectable notes-per-minute rates. It adds start, stop and pause control, plus loop and one-shot modes. Its outputs drive the note-RAM read address and the per-note strobe consumed by the display and scoring logic.

## Interface
- CLK_HZ, 50_000_000, clk frequency in Hz; all tick periods are derived from it at elaboration.
- ADDR_W, 6, note-memory address width.
- clk  in  1  system clock.
- resetn  in  1  reset resetn, synchronous, active-low; clock clk.
- start  in  1  one-cycle pulse: (re)start the sequence at start_addr.
- stop  in  1  one-cycle pulse: abort and return to IDLE.
- pause  in  1  level: hold the sequence while high.
- loop_en  in  1  1 = wrap from end_addr back to start_addr; 0 = one-shot.
- speed  in  3  rate select: 0..7 = 40, 60, 80, 100, 120, 140, 180, 220 notes/min.
- start_addr  in  ADDR_W  first note address; sampled on start.
- end_addr  in  ADDR_W  last note address; compared live.
- address  out  ADDR_W  current note address.
- step  out  1  one-cycle pulse in the cycle a new address becomes valid.
- running  out  1  high in RUN or PAUSE.
- done  out  1  high in DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Tick period is P = round(CLK_HZ*60/rate[speed]).
  - At 50 MHz: 75000000, 50000000, 37500000, 30000000, 25000000, 21428571, 16666667, 13636364.
  - The counter is $clog2 of the maximum P bits wide.
- Command priority, highest first: resetn, stop, start, pause, tick.
- stop (any state) -> IDLE. address holds its value; step, running and done go to 0.
- start (any state) -> RUN.
  - address <= start_addr, step <= 1, counter <= P-1.
- RUN:
  - The counter decrements once per cycle.
  - At counter==0, if address != end_addr: address <= address+1 mod 2^ADDR_W, step <= 1, counter <= P-1.
  - At counter==0, if address == end_addr and loop_en=1: address <= start_addr, step <= 1, counter <= P-1.
  - At counter==0, if address == end_addr and loop_en=0: -> DONE. No step; address holds.
- speed is sampled only at a reload. A mid-interval speed change takes effect at the next interval.
- pause high in RUN -> PAUSE. The counter and address freeze, including when the counter is at 0.
- pause low in PAUSE -> RUN. The counter resumes from its frozen value.
- pause in IDLE or DONE is ignored.
- start_addr > end_addr is legal: the address wraps through 2^ADDR_W-1 to 0.
- start_addr == end_addr: one-shot emits a single step then reaches DONE after P cycles; loop re-steps the same address every P cycles.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - address 0, step 0, running 0, done 0.
- All outputs are registered.
- start sampled at edge N: address, step=1 and running=1 are visible after edge N.
- The next step fires at edge N+P. With no pause, consecutive steps are exactly P cycles apart.
- Each paused cycle adds exactly one cycle to the current interval.
- start and stop sampled on the same edge: stop wins.
- start sampled in the same cycle as counter==0: restart wins; exactly one step, with address=start_addr.
- DONE is entered at the edge where a one-shot interval expires. done stays 1 until start or stop.
- resetn low mid-sequence returns every output to its reset value at the next edge.

## Structure
- Package note_seq_pkg holds:
  - the state enum;
  - the 8-entry NOTES_PER_MIN table {40, 60, 80, 100, 120, 140, 180, 220};
  - a constant function returning P for a given CLK_HZ and speed index.
- Sub-module tick_divider is the loadable down-counter.
  - Inputs: period, load, hold.
  - Outputs: zero flag and counter value.
- note_sequencer contains the FSM and the address register.

## Test plan
Bench runs with CLK_HZ=1200, so P = 1800, 1200, 900, 720, 600, 514, 400, 327.
- Reset and start: start_addr=3, end_addr=6, speed=1, loop_en=0, pulse start -> steps at relative cycles 0, 1200, 2400, 3600 with addresses 3, 4, 5, 6; done=1 at cycle 4800; no fifth step.
- Loop with wrap-around: ADDR_W=6, start_addr=62, end_addr=1, loop_en=1, speed=7 -> addresses 62, 63, 0, 1, 62 ...; step spacing 327 cycles.
- Pause: speed=4, assert pause for 100 cycles at 250 cycles after a step -> next step at 700 cycles instead of 600; address unchanged while paused.
- Speed change mid-interval: speed 0 -> 7 at 500 cycles after a step -> the current interval still takes 1800 cycles; the next takes 327.
- Command collisions:
  - start and stop on the same cycle -> IDLE, no step.
  - start on the counter==0 cycle -> single step, address=start_addr.
- Reset mid-RUN: resetn low for 1 cycle -> address=0, step=0, running=0, done=0; start pulses are ignored while resetn is low.

Source files
------------

// File: rtl/note_seq_pkg.sv
// Shared types and tempo arithmetic for the note sequencer.
// Latency: n/a (elaboration-time constants and types only).
// Backpressure: n/a.
package note_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } seq_state_t;

  localparam int unsigned NOTES_PER_MIN [8] = '{40, 60, 80, 100, 120, 140, 180, 220};

  // Clock cycles per note, rounded to nearest: (clk_hz*60 + rate/2) / rate.
  function automatic longint unsigned tick_period(longint unsigned clk_hz,
                                                  int unsigned idx);
    longint unsigned rate;
    rate = 64'(NOTES_PER_MIN[idx]);
    return (clk_hz * 64'd60 + rate / 64'd2) / rate;
  endfunction

  // Longest interval over the rate table; sizes the down-counter.
  function automatic longint unsigned max_tick_period(longint unsigned clk_hz);
    longint unsigned m;
    m = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (tick_period(clk_hz, i) > m) m = tick_period(clk_hz, i);
    end
    return m;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Loadable down-counter that times one note interval.
// Latency: load takes effect at the next edge; zero is decoded from the count.
// Backpressure: hold freezes the count; it stops at zero until reloaded.
// Ports: clk/resetn; period = interval length in cycles (loads period-1);
//        load, hold controls; zero flag and current count.
module tick_divider #(
  parameter int unsigned CNT_W = 27
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [CNT_W:0]   period,
  input  logic             load,
  input  logic             hold,
  output logic             zero,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W:0] reload_val;

  assign reload_val = period - 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= reload_val[CNT_W-1:0];
    end else if (!hold && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/note_sequencer.sv
// Tempo-driven sequencer walking a note-memory address window at a selectable rate.
// Latency: start shows address/step/running after one edge; steps are P cycles apart.
// Backpressure: pause level freezes interval and address; each paused cycle adds one.
// Ports: clk, resetn (sync, active-low); start/stop pulses, pause level, loop_en,
//        speed[2:0], start_addr/end_addr window -> address, step, running, done.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [2:0]        speed,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] address,
  output logic              step,
  output logic              running,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(max_tick_period(64'(CLK_HZ)));
  localparam int unsigned PER_W = CNT_W + 1;

  seq_state_t        state;
  logic [ADDR_W-1:0] first_addr;   // start_addr captured at start; loop target
  logic [PER_W-1:0]  period_tbl [8];
  logic [PER_W-1:0]  period_sel;
  logic              tick_zero;
  logic [CNT_W-1:0]  tick_count;
  logic              run_active;
  logic              expire;
  logic              at_end;
  logic              div_load;
  logic              div_hold;
  logic              unused_count;

  for (genvar g = 0; g < 8; g++) begin : g_period
    assign period_tbl[g] = PER_W'(tick_period(64'(CLK_HZ), g));
  end

  // speed only matters when the divider reloads, so a mid-interval change
  // naturally applies from the next interval.
  assign period_sel = period_tbl[speed];

  // PAUSE with pause released behaves as RUN on the same edge, so exactly
  // one cycle is added per paused cycle.
  assign run_active = ((state == ST_RUN) || (state == ST_PAUSE)) && !pause;
  assign expire     = run_active && tick_zero;
  assign at_end     = (address == end_addr);

  assign div_load = !stop && (start || (expire && (!at_end || loop_en)));
  assign div_hold = stop || start || !run_active;

  tick_divider #(
    .CNT_W (CNT_W)
  ) u_tick_divider (
    .clk    (clk),
    .resetn (resetn),
    .period (period_sel),
    .load   (div_load),
    .hold   (div_hold),
    .zero   (tick_zero),
    .count  (tick_count)
  );

  // Count value is only needed for debug visibility.
  assign unused_count = ^tick_count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      address    <= '0;
      first_addr <= '0;
      step       <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      step <= 1'b0;
      if (stop) begin
        state   <= ST_IDLE;
        running <= 1'b0;
        done    <= 1'b0;
      end else if (start) begin
        state      <= ST_RUN;
        address    <= start_addr;
        first_addr <= start_addr;
        step       <= 1'b1;
        running    <= 1'b1;
        done       <= 1'b0;
      end else if ((state == ST_RUN) || (state == ST_PAUSE)) begin
        if (pause) begin
          state <= ST_PAUSE;
        end else begin
          state <= ST_RUN;
          if (expire) begin
            if (!at_end) begin
              address <= address + 1'b1;
              step    <= 1'b1;
            end else if (loop_en) begin
              address <= first_addr;
              step    <= 1'b1;
            end else begin
              state   <= ST_DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed tempo scenarios plus a randomized phase,
// all outputs compared every cycle against a behavioural interval model.
// Runs at CLK_HZ=1200 so intervals are a few hundred to 1800 cycles.
module tb_note_sequencer;

  localparam int unsigned CLK_HZ = 1200;
  localparam int unsigned ADDR_W = 6;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              pause = 1'b0;
  logic              loop_en = 1'b0;
  logic [2:0]        speed = 3'd0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic [ADDR_W-1:0] address;
  logic              step;
  logic              running;
  logic              done;

  note_sequencer #(
    .CLK_HZ (CLK_HZ),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .loop_en    (loop_en),
    .speed      (speed),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .address    (address),
    .step       (step),
    .running    (running),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int log_c[$];
  int log_a[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc_cnt);
    end
  endtask

  // Notes-per-minute to cycles, with real-valued rounding.
  function automatic int cycles_per_note(input int s);
    int  rates [8];
    real r;
    rates = '{40, 60, 80, 100, 120, 140, 180, 220};
    r = real'(CLK_HZ) * 60.0 / real'(rates[s]);
    return int'($floor(r + 0.5));
  endfunction

  // Behavioural model: "left" counts cycles until the next note boundary.
  bit m_on = 0;
  bit m_done = 0;
  bit m_step = 0;
  int m_addr = 0;
  int m_first = 0;
  int m_left = 0;

  bit s_resetn, s_start, s_stop, s_pause, s_loop;
  int s_speed, s_start_addr, s_end_addr;

  task automatic model_advance();
    if (!s_resetn) begin
      m_on = 0; m_done = 0; m_addr = 0; m_step = 0; m_first = 0;
    end else if (s_stop) begin
      m_on = 0; m_done = 0; m_step = 0;
    end else if (s_start) begin
      m_on = 1; m_done = 0; m_step = 1;
      m_addr = s_start_addr; m_first = s_start_addr;
      m_left = cycles_per_note(s_speed);
    end else begin
      m_step = 0;
      if (m_on && !s_pause) begin
        m_left--;
        if (m_left == 0) begin
          if (m_addr != s_end_addr) begin
            m_addr = (m_addr + 1) % (1 << ADDR_W);
            m_step = 1;
            m_left = cycles_per_note(s_speed);
          end else if (s_loop) begin
            m_addr = m_first;
            m_step = 1;
            m_left = cycles_per_note(s_speed);
          end else begin
            m_on = 0;
            m_done = 1;
          end
        end
      end
    end
  endtask

  // Sample inputs at the active edge, compare outputs at the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      s_resetn = resetn; s_start = start; s_stop = stop; s_pause = pause;
      s_loop = loop_en; s_speed = int'(speed);
      s_start_addr = int'(start_addr); s_end_addr = int'(end_addr);
      cyc_cnt++;
      @(negedge clk);
      model_advance();
      check_eq("model_outs", {23'd0, address, step, running, done},
               {23'd0, 6'(m_addr), m_step, m_on, m_done});
      if (step === 1'b1) begin
        log_c.push_back(cyc_cnt);
        log_a.push_back(int'(address));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc_cnt < target) cyc();
  endtask

  task automatic pulse_start(output int n0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    n0 = cyc_cnt;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
    log_c.delete();
    log_a.delete();
  endtask

  // Compare logged steps against expected (relative cycle, address) pairs.
  task automatic check_log(input string tag, input int n0, input int rel[$],
                           input int adr[$]);
    check_eq({tag, "_count"}, log_c.size(), rel.size());
    for (int i = 0; i < rel.size() && i < log_c.size(); i++) begin
      check_eq({tag, "_time"}, log_c[i] - n0, rel[i]);
      check_eq({tag, "_addr"}, log_a[i], adr[i]);
    end
  endtask

  initial begin
    int n0;
    repeat (3) cyc();
    check_eq("reset_outs", {23'd0, address, step, running, done}, 32'd0);
    resetn = 1'b1;
    cyc();

    // One-shot window 3..6 at 60 notes/min.
    go_idle();
    start_addr = 6'd3; end_addr = 6'd6; speed = 3'd1; loop_en = 1'b0;
    pulse_start(n0);
    check_eq("start_running", running, 1);
    wait_until(n0 + 4799);
    check_eq("done_early", done, 0);
    cyc();
    check_eq("done_set", done, 1);
    check_eq("done_running", running, 0);
    wait_until(n0 + 4900);
    check_log("oneshot", n0, '{0, 1200, 2400, 3600}, '{3, 4, 5, 6});

    // Looping window that wraps through the top of the address space.
    go_idle();
    start_addr = 6'd62; end_addr = 6'd1; speed = 3'd7; loop_en = 1'b1;
    pulse_start(n0);
    wait_until(n0 + 1310);
    check_log("wrap", n0, '{0, 327, 654, 981, 1308}, '{62, 63, 0, 1, 62});

    // 100 paused cycles stretch a 600-cycle interval to 700.
    go_idle();
    start_addr = 6'd0; end_addr = 6'd10; speed = 3'd4; loop_en = 1'b0;
    pulse_start(n0);
    wait_until(n0 + 250);
    pause = 1'b1;
    wait_until(n0 + 350);
    check_eq("pause_running", running, 1);
    check_eq("pause_addr", address, 0);
    pause = 1'b0;
    wait_until(n0 + 702);
    check_log("pause", n0, '{0, 700}, '{0, 1});

    // Mid-interval speed change applies from the following interval.
    go_idle();
    start_addr = 6'd10; end_addr = 6'd20; speed = 3'd0;
    pulse_start(n0);
    wait_until(n0 + 500);
    speed = 3'd7;
    wait_until(n0 + 2130);
    check_log("speedchg", n0, '{0, 1800, 2127}, '{10, 11, 12});

    // start and stop together while running: stop wins.
    log_c.delete(); log_a.delete();
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    check_eq("collide_ss", {29'd0, step, running, done}, 32'd0);
    repeat (5) cyc();
    check_eq("collide_ss_steps", log_c.size(), 0);

    // start on the expiry cycle: one step at the new start address.
    go_idle();
    start_addr = 6'd5; end_addr = 6'd30; speed = 3'd6;
    pulse_start(n0);
    wait_until(n0 + 399);
    start_addr = 6'd40;
    pulse_start(n0);
    n0 = n0 - 400;
    wait_until(n0 + 802);
    check_log("restart_zero", n0, '{0, 400, 800}, '{5, 40, 41});

    // Reset mid-run; a start during reset is ignored.
    wait_until(n0 + 900);
    resetn = 1'b0; start = 1'b1;
    cyc();
    check_eq("rst_mid", {23'd0, address, step, running, done}, 32'd0);
    resetn = 1'b1; start = 1'b0;
    cyc();
    check_eq("rst_after", {23'd0, address, step, running, done}, 32'd0);

    // Randomized commands, checked cycle by cycle by the model.
    for (int i = 0; i < 15000; i++) begin
      start = ($urandom_range(0, 499) == 0);
      stop  = ($urandom_range(0, 1999) == 0);
      if (start) begin
        start_addr = 6'($urandom_range(0, 63));
        end_addr   = start_addr + 6'($urandom_range(0, 4));
        loop_en    = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 2999) == 0) end_addr = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 399) == 0) speed = 3'($urandom_range(0, 7));
      if (!pause && $urandom_range(0, 299) == 0) pause = 1'b1;
      else if (pause && $urandom_range(0, 19) == 0) pause = 1'b0;
      resetn = ($urandom_range(0, 4999) != 0);
      cyc();
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0; resetn = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
